// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, parity modes, parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Expected parity bit for a frame; narrower data is zero-extended by the caller.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Receive FIFO: extra-MSB pointers, head read combinationally from storage.
module uart_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd_en = i_pop && !o_empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_wr_en = i_push && (!o_full || w_rd_en);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; natural wrap through the extra MSB
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty masks the head
    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote sampling and a four-phase-acked receive FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_uart_clk,
    input  logic                 i_reset_n,
    input  logic                 i_uart_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_data_rdy,
    input  logic                 i_rdy_ack,
    output logic                 o_rdy_ack_clr,
    output logic                 o_overrun
);
    localparam int CW    = $clog2(OVERSAMPLE);
    localparam int WIDTH = DATA_BITS + 2;

    rx_state_t            r_state;
    rx_state_t            w_next;
    logic                 r_rx_meta, r_rx_sync, r_rx_prev;
    logic                 r_ack_meta, r_ack_sync, r_ack_prev;
    logic [2:0]           r_arm;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_s0, r_s1;
    logic                 r_perr, r_ferr;
    logic                 r_ack_clr, r_overrun;
    logic                 w_fall, w_bit_end, w_vote_pt, w_vote;
    logic                 w_last_data, w_last_stop, w_entry_ferr;
    logic                 w_push, w_pop, w_drop, w_full, w_empty;
    logic [WIDTH-1:0]     w_head;

    // r_arm fills once the sync chain and r_rx_prev hold real line values, so a line
    // that is low at reset release is not mistaken for a fresh start edge
    assign w_fall       = r_arm[2] && r_rx_prev && !r_rx_sync;
    assign w_bit_end    = (r_cnt == CW'(OVERSAMPLE - 1));
    assign w_vote_pt    = (r_cnt == CW'(OVERSAMPLE / 2 + 1));
    assign w_vote       = (r_s0 & r_s1) | (r_s0 & r_rx_sync) | (r_s1 & r_rx_sync);
    assign w_last_data  = (r_bit_idx == 3'(DATA_BITS - 1));
    assign w_last_stop  = (r_bit_idx == 3'(STOP_BITS - 1));
    assign w_entry_ferr = r_ferr | ~w_vote;
    assign w_pop        = r_ack_sync && !r_ack_prev && !w_empty;
    assign w_drop       = w_push && w_full && !w_pop;

    // Input synchronisers, edge-detect history and post-reset arming
    always_ff @(posedge i_uart_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_ack_meta <= 1'b0;
            r_ack_sync <= 1'b0;
            r_ack_prev <= 1'b0;
            r_arm      <= '0;
        end else begin
            r_rx_meta  <= i_uart_rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_ack_meta <= i_rdy_ack;
            r_ack_sync <= r_ack_meta;
            r_ack_prev <= r_ack_sync;
            r_arm      <= {r_arm[1:0], 1'b1};
        end
    end

    // Receiver state register
    always_ff @(posedge i_uart_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_next;
    end

    // Receiver next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:       if (w_fall) w_next = ST_START;
            ST_START: begin
                if (w_vote_pt && w_vote) w_next = ST_IDLE;
                else if (w_bit_end)      w_next = ST_DATA;
            end
            ST_DATA:       if (w_bit_end && w_last_data)
                               w_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY:     if (w_bit_end) w_next = ST_STOP;
            ST_STOP:       if (w_vote_pt && w_last_stop)
                               w_next = w_entry_ferr ? ST_BREAK_WAIT : ST_IDLE;
            ST_BREAK_WAIT: if (r_rx_sync) w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
    end

    // Receiver outputs: push the entry at the final stop-bit vote
    always_comb begin
        w_push = 1'b0;
        if (r_state == ST_STOP && w_vote_pt && w_last_stop) w_push = 1'b1;
    end

    // Bit timing, sampling, data shift and per-frame error accumulation
    always_ff @(posedge i_uart_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            if (r_state == ST_IDLE || r_state == ST_BREAK_WAIT || w_next != r_state || w_bit_end)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (w_next != r_state) r_bit_idx <= '0;
            else if (w_bit_end)    r_bit_idx <= r_bit_idx + 1'b1;
            if (r_cnt == CW'(OVERSAMPLE / 2 - 1)) r_s0 <= r_rx_sync;
            if (r_cnt == CW'(OVERSAMPLE / 2))     r_s1 <= r_rx_sync;
            if (r_state == ST_START) begin
                r_perr <= 1'b0;
                r_ferr <= 1'b0;
            end
            if (r_state == ST_DATA && w_vote_pt)
                r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            if (r_state == ST_PARITY && w_vote_pt)
                r_perr <= (w_vote != parity_bit(8'(r_shift), PARITY));
            if (r_state == ST_STOP && w_vote_pt && !w_vote)
                r_ferr <= 1'b1;
        end
    end

    // Consumer acknowledge handshake and sticky overrun
    always_ff @(posedge i_uart_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ack_clr <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_pop)            r_ack_clr <= 1'b1;
            else if (!r_ack_sync) r_ack_clr <= 1'b0;
            if (w_drop)           r_overrun <= 1'b1;
            else if (w_pop)       r_overrun <= 1'b0;
        end
    end

    uart_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_uart_clk),
        .i_rst_n (i_reset_n),
        .i_push  (w_push),
        .i_wdata ({r_shift, r_perr, w_entry_ferr}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign o_data_rdy    = !w_empty;
    assign o_data        = w_empty ? '0 : w_head[WIDTH-1:2];
    assign o_parity_err  = !w_empty && w_head[1];
    assign o_frame_err   = !w_empty && w_head[0];
    assign o_rdy_ack_clr = r_ack_clr;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: a default 8N1 receiver and an even-parity receiver side by side.
module tb_uart_rx_fifo;

    localparam int OS = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic       ack0 = 1'b0, ack1 = 1'b0;
    logic [7:0] d0, d1;
    logic       pe0, pe1, fe0, fe1, rdy0, rdy1, clr0, clr1, ov0, ov1;

    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];
    bit   exp_ov[2];
    bit   consume[2];
    int   pops[2];

    always #5 clk = ~clk;

    uart_rx_fifo u_dut (
        .i_uart_clk    (clk),
        .i_reset_n     (rst_n),
        .i_uart_rx     (rx0),
        .o_data        (d0),
        .o_parity_err  (pe0),
        .o_frame_err   (fe0),
        .o_data_rdy    (rdy0),
        .i_rdy_ack     (ack0),
        .o_rdy_ack_clr (clr0),
        .o_overrun     (ov0)
    );

    uart_rx_fifo #(
        .PARITY (1)
    ) u_dut_par (
        .i_uart_clk    (clk),
        .i_reset_n     (rst_n),
        .i_uart_rx     (rx1),
        .o_data        (d1),
        .o_parity_err  (pe1),
        .o_frame_err   (fe1),
        .o_data_rdy    (rdy1),
        .i_rdy_ack     (ack1),
        .o_rdy_ack_clr (clr1),
        .o_overrun     (ov1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic get_rdy(input int w);
        return (w == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic get_clr(input int w);
        return (w == 0) ? clr0 : clr1;
    endfunction

    task automatic set_ack(input int w, input logic v);
        if (w == 0) ack0 = v;
        else        ack1 = v;
    endtask

    task automatic drive_bit(input int w, input logic v);
        @(negedge clk);
        if (w == 0) rx0 = v;
        else        rx1 = v;
        repeat (OS - 1) @(negedge clk);
    endtask

    // Reference: entry content follows from the frame as sent; a full FIFO drops it.
    task automatic send_frame(input int w, input logic [7:0] d, input bit bad_par, input bit stop_val);
        exp_t e;
        int   qs;
        e.d  = d;
        e.pe = bad_par;
        e.fe = !stop_val;
        qs = (w == 0) ? q0.size() : q1.size();
        if (qs < 4) begin
            if (w == 0) q0.push_back(e);
            else        q1.push_back(e);
        end else begin
            exp_ov[w] = 1'b1;
        end
        drive_bit(w, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(w, d[i]);
        if (w == 1) drive_bit(w, (^d) ^ bad_par);
        drive_bit(w, stop_val);
    endtask

    task automatic monitor(input int w);
        exp_t e;
        int   n;
        logic [7:0] ad;
        logic ape, afe, aov;
        forever begin
            @(posedge clk);
            #1;
            if (consume[w] && get_rdy(w)) begin
                ad  = (w == 0) ? d0 : d1;
                ape = (w == 0) ? pe0 : pe1;
                afe = (w == 0) ? fe0 : fe1;
                aov = (w == 0) ? ov0 : ov1;
                if (((w == 0) ? q0.size() : q1.size()) == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut%0d_unexpected_entry: got data 0x%0h expected no entry", w, ad);
                end else begin
                    e = (w == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("dut%0d_data", w), 32'(ad), 32'(e.d));
                    chk($sformatf("dut%0d_parity_err", w), 32'(ape), 32'(e.pe));
                    chk($sformatf("dut%0d_frame_err", w), 32'(afe), 32'(e.fe));
                    chk($sformatf("dut%0d_overrun", w), 32'(aov), 32'(exp_ov[w]));
                end
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
                set_ack(w, 1'b1);
                n = 0;
                while (!get_clr(w) && n < 12) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk($sformatf("dut%0d_ack_clr_high", w), 32'(get_clr(w)), 32'd1);
                exp_ov[w] = 1'b0;
                pops[w]++;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                chk($sformatf("dut%0d_ack_clr_held", w), 32'(get_clr(w)), 32'd1);
                set_ack(w, 1'b0);
                n = 0;
                while (get_clr(w) && n < 12) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk($sformatf("dut%0d_ack_clr_low", w), 32'(get_clr(w)), 32'd0);
            end
        end
    endtask

    task automatic wait_drain(input int w);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < 4000) begin
            @(negedge clk);
            n++;
            busy = (((w == 0) ? q0.size() : q1.size()) != 0) || get_rdy(w) || get_clr(w);
        end
        chk($sformatf("dut%0d_drain_timeout", w), 32'(busy), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         p;
        bit         saw;
        logic [7:0] v;
        logic [7:0] partial;
        int         w;

        consume[0] = 1'b1;
        consume[1] = 1'b1;
        fork
            monitor(0);
            monitor(1);
        join_none

        repeat (3) @(negedge clk);
        chk("rst_data_rdy", 32'(rdy0), 32'd0);
        chk("rst_ack_clr", 32'(clr0), 32'd0);
        chk("rst_overrun", 32'(ov0), 32'd0);
        chk("rst_data", 32'(d0), 32'd0);
        chk("rst_parity_err", 32'(pe0), 32'd0);
        chk("rst_frame_err", 32'(fe0), 32'd0);
        chk("rst_par_data_rdy", 32'(rdy1), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // basic 8N1 frame with full handshake
        send_frame(0, 8'h55, 1'b0, 1'b1);
        wait_drain(0);
        chk("basic_pop_count", 32'(pops[0]), 32'd1);

        // ack edge with empty FIFO must not produce ack_clr
        consume[0] = 1'b0;
        @(negedge clk);
        ack0 = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (clr0) saw = 1'b1;
        end
        chk("empty_ack_clr", 32'(saw), 32'd0);
        ack0 = 1'b0;
        repeat (5) @(negedge clk);
        consume[0] = 1'b1;

        // even parity: correct then wrong parity bit
        send_frame(1, 8'hA5, 1'b0, 1'b1);
        send_frame(1, 8'hA5, 1'b1, 1'b1);
        wait_drain(1);

        // framing error followed by a long break
        p = pops[0];
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        repeat (40 * OS) @(negedge clk);
        chk("break_single_entry", 32'(pops[0] - p), 32'd1);
        chk("break_no_data", 32'(rdy0), 32'd0);
        rx0 = 1'b1;
        repeat (2 * OS) @(negedge clk);
        send_frame(0, 8'h12, 1'b0, 1'b1);
        wait_drain(0);

        // short low glitch on an idle line
        p = pops[0];
        @(negedge clk);
        rx0 = 1'b0;
        repeat (4) @(negedge clk);
        rx0 = 1'b1;
        repeat (3 * OS) @(negedge clk);
        chk("glitch_no_push", 32'(pops[0] - p), 32'd0);
        chk("glitch_no_data", 32'(rdy0), 32'd0);
        send_frame(0, 8'h81, 1'b0, 1'b1);
        wait_drain(0);

        // overrun: five frames into a four-entry FIFO without acks
        consume[0] = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b1);
        repeat (OS) @(negedge clk);
        chk("overrun_set", 32'(ov0), 32'(exp_ov[0]));
        chk("overrun_data_rdy", 32'(rdy0), 32'd1);
        consume[0] = 1'b1;
        wait_drain(0);
        chk("overrun_cleared", 32'(ov0), 32'd0);

        // reset in the middle of a frame with one entry pending
        consume[0] = 1'b0;
        send_frame(0, 8'h99, 1'b0, 1'b1);
        repeat (OS) @(negedge clk);
        chk("pre_reset_data_rdy", 32'(rdy0), 32'd1);
        partial = 8'hC3;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, partial[i]);
        @(negedge clk);
        rx0 = partial[3];
        repeat (OS / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_data_rdy", 32'(rdy0), 32'd0);
        chk("midrst_data", 32'(d0), 32'd0);
        chk("midrst_ack_clr", 32'(clr0), 32'd0);
        chk("midrst_overrun", 32'(ov0), 32'd0);
        q0.delete();
        exp_ov[0] = 1'b0;
        rx0 = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        consume[0] = 1'b1;
        repeat (2 * OS) @(negedge clk);
        p = pops[0];
        send_frame(0, 8'h7E, 1'b0, 1'b1);
        wait_drain(0);
        chk("post_reset_single_entry", 32'(pops[0] - p), 32'd1);

        // randomized traffic on both receivers
        for (int i = 0; i < 12; i++) begin
            w = int'($urandom_range(0, 1));
            v = 8'($urandom);
            send_frame(w, v, (w == 1) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1);
            repeat ($urandom_range(0, 2) * OS) @(negedge clk);
        end
        wait_drain(0);
        wait_drain(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
